spi_frame_rx: RTL

Parametrised SPI slave that receives one fixed-length frame per chip-select assertion and commits it atomically to a double-buffered parallel output register. It replaces the fixed-width SPI receive path inside `top` that loads `synth_t` from the control MCU. Frame length, bit order and clock polarity are configurable. It adds framing-error detection, a frame counter, and a MISO status/echo channel. All SPI inputs are oversampled in the system clock domain, so no SPI-clocked logic exists.

---
 rtl/spi_frame_rx_pkg.sv | 31 +++
 rtl/spi_frame_rx_sync_2ff.sv | 25 ++
 rtl/spi_frame_rx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_frame_rx_pkg.sv
// Shared types and constants for the SPI frame receiver and the
// parallel control word it loads.
package spi_frame_rx_pkg;

    localparam int SPI_STATUS_W        = 8;
    localparam int SPI_MIN_HALF_PERIOD = 4;

    typedef struct packed {
        logic [6:0] count;
        logic       err;
    } spi_status_t;

    typedef struct packed {
        logic [7:0] ctrl;
        logic [7:0] gain;
        logic [7:0] pitch;
        logic [7:0] level;
    } synth_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_END
    } rx_state_t;

    // Bit position within a byte for the n-th bit on the wire.
    function automatic logic [2:0] bit_pos(input logic msb_first, input logic [2:0] cnt);
        return msb_first ? ~cnt : cnt;
    endfunction

endpackage

// File: rtl/spi_frame_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, resetting to a
// caller-chosen idle value so no false edge appears after reset.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= RESET_VAL;
            q       <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/spi_frame_rx.sv
// Oversampled SPI slave (CPHA=0): receives one fixed-length frame per chip
// select and commits it atomically to frame_o, echoing status/data on miso.
module spi_frame_rx
    import spi_frame_rx_pkg::*;
#(
    parameter int FRAME_BYTES = $bits(synth_t) / 8,
    parameter int MSB_FIRST   = 0,
    parameter int CPOL        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     csel,
    input  logic                     mosi,
    output logic                     miso,
    output logic [FRAME_BYTES*8-1:0] frame_o,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [15:0]              frame_count
);

    localparam int                FW         = FRAME_BYTES * 8;
    localparam int                BCW        = $clog2(FRAME_BYTES + 2);
    localparam logic              CPOL_L     = (CPOL != 0);
    localparam logic              MSB_L      = (MSB_FIRST != 0);
    localparam logic [BCW-1:0]    BYTES_FULL = BCW'(FRAME_BYTES);
    localparam logic [BCW-1:0]    BYTES_SAT  = BCW'(FRAME_BYTES + 1);

    logic [1:0] ctl_s;
    logic       sclk_s, csel_s, mosi_s, sclk_d, csel_d;

    sync_2ff #(.WIDTH(2), .RESET_VAL({CPOL_L, 1'b1})) u_sync_ctl (
        .clk (clk),
        .rst (rst),
        .d   ({sclk, csel}),
        .q   (ctl_s)
    );

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    assign sclk_s = ctl_s[1];
    assign csel_s = ctl_s[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d <= CPOL_L;
            csel_d <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            csel_d <= csel_s;
        end
    end

    logic sample_edge, shift_edge, csel_fall, csel_rise;

    // Sample on the edge leaving the idle level, shift miso on the return edge.
    assign sample_edge = (sclk_s != sclk_d) && (sclk_d == CPOL_L);
    assign shift_edge  = (sclk_s != sclk_d) && (sclk_d != CPOL_L);
    assign csel_fall   = csel_d & ~csel_s;
    assign csel_rise   = ~csel_d & csel_s;

    rx_state_t                 state;
    logic [2:0]                bit_cnt;
    logic [BCW-1:0]            byte_cnt;
    logic                      overrun;
    logic                      last_err;
    logic [7:0]                shreg;
    logic [7:0]                last_byte;
    logic [FW-1:0]             stage;
    logic [7:0]                byte_next;
    logic [SPI_STATUS_W-1:0]   status_bits;
    logic [7:0]                tx_byte;
    spi_status_t               status;

    always_comb begin
        byte_next = shreg;
        byte_next[bit_pos(MSB_L, bit_cnt)] = mosi_s;
    end

    assign status      = '{count: frame_count[6:0], err: last_err};
    assign status_bits = status;
    assign tx_byte     = (byte_cnt == '0) ? status_bits : last_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            overrun     <= 1'b0;
            last_err    <= 1'b0;
            shreg       <= '0;
            last_byte   <= '0;
            stage       <= '0;
            frame_o     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            miso        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    miso <= 1'b0;
                    if (csel_fall) begin
                        state    <= ST_RECV;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        overrun  <= 1'b0;
                        shreg    <= '0;
                        miso     <= status_bits[bit_pos(MSB_L, 3'd0)];
                    end
                end
                ST_RECV: begin
                    if (csel_rise) begin
                        state <= ST_END;
                        miso  <= 1'b0;
                    end else if (sample_edge) begin
                        shreg   <= byte_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            last_byte <= byte_next;
                            // Bytes arrive in order, so shifting up leaves byte 0 at the top.
                            if (byte_cnt < BYTES_FULL)
                                stage <= FW'({stage, byte_next});
                            else
                                overrun <= 1'b1;
                            if (byte_cnt != BYTES_SAT)
                                byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (shift_edge) begin
                        miso <= tx_byte[bit_pos(MSB_L, bit_cnt)];
                    end
                end
                ST_END: begin
                    if (byte_cnt == BYTES_FULL && bit_cnt == 3'd0 && !overrun) begin
                        frame_o     <= stage;
                        frame_valid <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        last_err    <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        last_err  <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
